// File: rtl/frame_draw_scheduler_pkg.sv
// Shared constants and FSM state encoding for the per-frame layer draw scheduler.
package frame_draw_scheduler_pkg;
  localparam int VGA_COOR_WIDTH = 12;
  localparam int VGA_FRAME_W    = 1280;
  localparam int VGA_FRAME_H    = 300;
  localparam int PAL_W          = 3;
  localparam logic [PAL_W-1:0] PALETTE_TRANSPARENT = '0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_LOW = 3'd1,
    GRANT    = 3'd2,
    DRAW     = 3'd3,
    NEXT     = 3'd4
  } sched_state_t;
endpackage

// File: rtl/frame_draw_scheduler_layer_pixel_mux.sv
// Selects the granted layer's packed pixel fields and flags whether the pixel lies on screen.
module frame_draw_scheduler_layer_pixel_mux
  import frame_draw_scheduler_pkg::*;
#(
  parameter int N_LAYERS   = 4,
  parameter int COOR_WIDTH = VGA_COOR_WIDTH,
  parameter int FRAME_W    = VGA_FRAME_W,
  parameter int FRAME_H    = VGA_FRAME_H,
  parameter int LIDX_W     = 2
) (
  input  logic [LIDX_W-1:0]              layer_idx,
  input  logic [N_LAYERS-1:0]            pix_valid,
  input  logic [N_LAYERS*COOR_WIDTH-1:0] pix_x,
  input  logic [N_LAYERS*COOR_WIDTH-1:0] pix_y,
  input  logic [N_LAYERS*PAL_W-1:0]      pix_palette,
  input  logic [N_LAYERS-1:0]            req_done,
  output logic                           sel_valid,
  output logic                           sel_done,
  output logic [COOR_WIDTH-1:0]          sel_x,
  output logic [COOR_WIDTH-1:0]          sel_y,
  output logic [PAL_W-1:0]               sel_palette,
  output logic                           sel_in_range
);
  always_comb begin
    sel_valid   = 1'b0;
    sel_done    = 1'b0;
    sel_x       = '0;
    sel_y       = '0;
    sel_palette = PALETTE_TRANSPARENT;
    for (int k = 0; k < N_LAYERS; k++) begin
      if (layer_idx == LIDX_W'(k)) begin
        sel_valid   = pix_valid[k];
        sel_done    = req_done[k];
        sel_x       = pix_x[k*COOR_WIDTH +: COOR_WIDTH];
        sel_y       = pix_y[k*COOR_WIDTH +: COOR_WIDTH];
        sel_palette = pix_palette[k*PAL_W +: PAL_W];
      end
    end
  end

  assign sel_in_range = (sel_x < COOR_WIDTH'(FRAME_W)) && (sel_y < COOR_WIDTH'(FRAME_H));
endmodule

// File: rtl/frame_draw_scheduler.sv
// Grants layer producers back-to-front after each frame-swap tick and registers their pixels
// onto the frame buffer write port, with a per-layer watchdog and overrun recovery.
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
#(
  parameter int COOR_WIDTH    = VGA_COOR_WIDTH,
  parameter int N_LAYERS      = 4,
  parameter int FRAME_W       = VGA_FRAME_W,
  parameter int FRAME_H       = VGA_FRAME_H,
  parameter int TIMEOUT_W     = 20,
  parameter int LAYER_TIMEOUT = 500000
) (
  input  logic                           clk_33m,
  input  logic                           rst,
  input  logic                           rst_screen_33m,
  input  logic [N_LAYERS-1:0]            layer_enable,
  output logic [N_LAYERS-1:0]            req_start,
  output logic                           req_abort,
  input  logic [N_LAYERS-1:0]            pix_valid,
  input  logic [N_LAYERS*COOR_WIDTH-1:0] pix_x,
  input  logic [N_LAYERS*COOR_WIDTH-1:0] pix_y,
  input  logic [N_LAYERS*PAL_W-1:0]      pix_palette,
  input  logic [N_LAYERS-1:0]            req_done,
  output logic [COOR_WIDTH-1:0]          write_x,
  output logic [COOR_WIDTH-1:0]          write_y,
  output logic [PAL_W-1:0]               write_palette,
  output logic                           busy,
  output logic                           frame_overrun,
  output logic                           timeout_flag,
  output logic [15:0]                    overrun_count,
  output logic [2:0]                     fsm_state
);
  localparam int LW     = $clog2(N_LAYERS + 1);
  localparam int LIDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [LW-1:0]        END_LAYER = LW'(N_LAYERS);
  localparam logic [TIMEOUT_W-1:0] WD_LAST   = TIMEOUT_W'(LAYER_TIMEOUT - 1);

  sched_state_t           state, state_d;
  logic [LW-1:0]          layer, layer_d;
  logic [LIDX_W-1:0]      layer_idx;
  logic [N_LAYERS-1:0]    en_q, en_d;
  logic [TIMEOUT_W-1:0]   wd, wd_d;
  logic                   flag_d;
  logic [15:0]            overrun_cnt, cnt_d;
  logic                   screen_q, tick, write_en;
  logic                   sel_valid, sel_done, sel_in_range;
  logic [COOR_WIDTH-1:0]  sel_x, sel_y;
  logic [PAL_W-1:0]       sel_palette;

  assign layer_idx     = layer[LIDX_W-1:0];
  assign tick          = rst_screen_33m & ~screen_q;
  assign overrun_count = overrun_cnt;

  frame_draw_scheduler_layer_pixel_mux #(
    .N_LAYERS(N_LAYERS), .COOR_WIDTH(COOR_WIDTH), .FRAME_W(FRAME_W),
    .FRAME_H(FRAME_H), .LIDX_W(LIDX_W)
  ) u_mux (
    .layer_idx(layer_idx), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_palette(pix_palette), .req_done(req_done), .sel_valid(sel_valid),
    .sel_done(sel_done), .sel_x(sel_x), .sel_y(sel_y), .sel_palette(sel_palette),
    .sel_in_range(sel_in_range)
  );

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      state         <= IDLE;
      layer         <= '0;
      en_q          <= '0;
      wd            <= '0;
      timeout_flag  <= 1'b0;
      overrun_cnt   <= '0;
      screen_q      <= 1'b0;
      write_x       <= '0;
      write_y       <= '0;
      write_palette <= PALETTE_TRANSPARENT;
    end else begin
      state        <= state_d;
      layer        <= layer_d;
      en_q         <= en_d;
      wd           <= wd_d;
      timeout_flag <= flag_d;
      overrun_cnt  <= cnt_d;
      screen_q     <= rst_screen_33m;
      if (write_en) begin
        write_x       <= sel_x;
        write_y       <= sel_y;
        write_palette <= sel_palette;
      end else begin
        write_palette <= PALETTE_TRANSPARENT;
      end
    end
  end

  always_comb begin
    state_d = state;
    layer_d = layer;
    en_d    = en_q;
    wd_d    = wd;
    flag_d  = timeout_flag;
    cnt_d   = overrun_cnt;
    case (state)
      IDLE: if (tick) begin
        en_d    = layer_enable;
        flag_d  = 1'b0;
        layer_d = '0;
        state_d = WAIT_LOW;
      end
      // The frame buffer drops writes while the swap level is high, so hold off granting.
      WAIT_LOW: if (!rst_screen_33m) begin
        layer_d = '0;
        state_d = NEXT;
      end
      NEXT: begin
        if (layer == END_LAYER)   state_d = IDLE;
        else if (en_q[layer_idx]) state_d = GRANT;
        else                      layer_d = layer + LW'(1);
      end
      GRANT: begin
        wd_d    = '0;
        state_d = DRAW;
      end
      DRAW: begin
        wd_d = wd + TIMEOUT_W'(1);
        if (sel_done) begin
          layer_d = layer + LW'(1);
          state_d = NEXT;
        end else if (wd == WD_LAST) begin
          flag_d  = 1'b1;
          layer_d = layer + LW'(1);
          state_d = NEXT;
        end
      end
      default: state_d = IDLE;
    endcase
    // A tick outside IDLE overrides whatever the current state decided.
    if (tick && state != IDLE) begin
      state_d = WAIT_LOW;
      layer_d = '0;
      en_d    = layer_enable;
      flag_d  = timeout_flag;
      if (overrun_cnt != 16'hFFFF) cnt_d = overrun_cnt + 16'd1;
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    req_start     = (!rst && state == GRANT) ? (N_LAYERS'(1) << layer_idx) : '0;
    frame_overrun = !rst && tick && (state != IDLE);
    req_abort     = !rst && (state == DRAW) && (tick || (!sel_done && wd == WD_LAST));
    write_en      = (state == DRAW) && sel_valid && sel_in_range;
    fsm_state     = state;
  end
endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
- Sequences per-frame drawing into the VGA frame buffer write port in the clk_33m domain.
- Waits for the frame-swap tick (rst_screen_33m), then grants N_LAYERS pixel producers one at a time in fixed layer order (layer 0 = back, highest = front), so later layers overwrite earlier ones.
- Muxes the granted producer's pixel stream onto write_x/write_y/write_palette.
- Handles producer timeouts and frame overruns.

Parameters:
- COOR_WIDTH, 12, coordinate width, matches the frame buffer write port
- N_LAYERS, 4, number of producers/layers
- FRAME_W, 1280, frame width; x must be < FRAME_W
- FRAME_H, 300, frame height; y must be < FRAME_H
- TIMEOUT_W, 20, width of the per-layer watchdog counter
- LAYER_TIMEOUT, 500000, clk_33m cycles allowed per layer before abort

Ports:
- clk_33m  in  1  system clock
- rst  in  1  synchronous active-high reset
- rst_screen_33m  in  1  frame-swap level from the VGA block; high several cycles per frame
- layer_enable  in  N_LAYERS  per-layer enable, sampled at frame start
- req_start  out  N_LAYERS  one-cycle grant pulse to producer k
- req_abort  out  1  one-cycle pulse; the granted producer stops immediately
- pix_valid  in  N_LAYERS  producer pixel strobe
- pix_x  in  N_LAYERS*COOR_WIDTH  packed x; layer k at [k*COOR_WIDTH +: COOR_WIDTH]
- pix_y  in  N_LAYERS*COOR_WIDTH  packed y
- pix_palette  in  N_LAYERS*3  packed palette index; 0 = transparent
- req_done  in  N_LAYERS  producer finished its layer (one-cycle pulse)
- write_x  out  COOR_WIDTH  to frame buffer
- write_y  out  COOR_WIDTH  to frame buffer
- write_palette  out  3  to frame buffer; 0 = no write
- busy  out  1  high when state is not IDLE
- frame_overrun  out  1  one-cycle pulse when a frame tick arrives before drawing completes
- timeout_flag  out  1  sticky; set on any layer timeout, cleared at the next frame start
- overrun_count  out  16  saturating count of overruns

Behaviour:
- Reset: state=IDLE; all outputs 0; layer pointer 0; watchdog 0.
- tick = rising edge of rst_screen_33m, detected with one register (previous value).
- States: IDLE, WAIT_LOW, GRANT, DRAW, NEXT.
- IDLE: on tick, latch layer_enable into en_q, clear timeout_flag, layer=0, go to WAIT_LOW.
- WAIT_LOW: wait for rst_screen_33m == 0; nothing is issued while the tick is high, because the frame buffer drops writes during the tick. Then go to NEXT with layer=0.
- NEXT: scan from the current layer for the lowest enabled layer; at most one layer is skipped per cycle.
  - If an enabled layer is found, go to GRANT.
  - If layer reaches N_LAYERS, go to IDLE.
- GRANT: pulse req_start[layer] for one cycle, clear watchdog, go to DRAW.
- DRAW:
  - Only the granted layer's pix_* is observed; other layers' pix_valid and req_done are ignored.
  - On req_done[layer]: layer+1, go to NEXT.
  - A pixel valid in the same cycle as req_done is still written.
- Pixel path, 1-cycle registered latency:
  - Write condition: pix_valid[layer] and state==DRAW and x<FRAME_W and y<FRAME_H.
  - When the write condition holds, write_x/y/palette take the pixel in the next cycle.
  - Otherwise write_palette=0 (x/y hold). Out-of-range pixels are dropped silently.
- Watchdog: increments each DRAW cycle. On reaching LAYER_TIMEOUT-1 without done:
  - pulse req_abort
  - set timeout_flag
  - layer+1, go to NEXT
- Overrun: a tick in any state other than IDLE.
  - Pulse frame_overrun and increment overrun_count, saturating at 16'hFFFF.
  - If in DRAW, pulse req_abort.
  - Re-latch en_q and go to WAIT_LOW with layer=0. The new frame restarts from layer 0.
- Simultaneous events:
  - tick has priority over req_done and timeout.
  - req_done has priority over timeout in the same cycle, so no abort is issued.
- layer_enable changes mid-frame have no effect until the next tick.
- rst mid-DRAW: return to IDLE; no req_abort is issued (producers share rst).

Decomposition:
- Shared package (e.g. vga_pkg): COOR_WIDTH, FRAME_W, FRAME_H, palette width 3, PALETTE_TRANSPARENT=0, state enum sched_state_t.
- One sub-module: layer_pixel_mux, a combinational select of the granted layer's packed pix_* fields plus the range check; the FSM and output register stay in the top.

Test Plan:
- Basic frame, layers 0..3 enabled:
  - Stimulus: tick high 3 cycles then low; each producer emits 2 pixels then done.
  - Required: req_start pulses in order 0,1,2,3; 8 writes appear 1 cycle after each valid; busy falls after layer 3 done.
- Masked layers:
  - Stimulus: layer_enable=4'b1010.
  - Required: only req_start[1] and req_start[3] pulse; layer_enable changed to 4'b1111 mid-frame has no effect.
- Range check:
  - Stimulus: pixels (1279,299,p=5), (1280,0,p=5), (0,300,p=5), (10,10,p=0).
  - Required: only the first produces write_palette=5; the others give write_palette=0.
- Timeout:
  - Stimulus: LAYER_TIMEOUT=16; layer 1 never asserts done.
  - Required: req_abort pulses 16 cycles after req_start[1]; timeout_flag=1; req_start[2] follows.
- Overrun:
  - Stimulus: tick during layer 2 DRAW.
  - Required: frame_overrun and req_abort pulse in the same cycle; overrun_count=1; after tick low, req_start[0] pulses again. Also check saturation when preloaded at 16'hFFFF.
- Same-cycle events:
  - Stimulus: req_done on the timeout cycle.
  - Required: no req_abort; timeout_flag stays 0.
- Reset mid-DRAW:
  - Required: the next cycle has busy=0 and write_palette=0.
